// File: rtl/dm_access_unit.sv
// Data-memory access unit: one load/store at a time over a req/ack bus,
// with byte-lane steering, load extension, legality checks and a timeout.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/ready    request handshake from EX (ready only when idle)
//   mem_we, mem_re     store / load select from the decoder
//   load_sel           0 lw/sw, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 sb
//   addr, wdata        byte address and store data
//   resp_valid         one-cycle completion pulse
//   rdata, err         extended load data and error flag, held between pulses
//   bus_req .. bus_wdata  registered bus request, stable while bus_req=1
//   bus_ack, bus_rdata    bus completion and read word
module dm_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [3:0]  load_sel,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [3:0] SEL_W   = 4'd0;
    localparam logic [3:0] SEL_B   = 4'd1;
    localparam logic [3:0] SEL_BU  = 4'd2;
    localparam logic [3:0] SEL_H   = 4'd3;
    localparam logic [3:0] SEL_HU  = 4'd4;
    localparam logic [3:0] SEL_SB  = 4'd5;

    // Last count value before the access is abandoned.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  sel_q, sel_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        is_store;
    logic        legal;
    logic [3:0]  be_new;
    logic [31:0] wd_new;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;

    // Request decode: store wins when both strobes are set.
    always_comb begin
        is_store = mem_we;
        legal    = 1'b0;
        if (is_store) begin
            unique case (load_sel)
                SEL_W:   legal = (addr[1:0] == 2'b00);
                SEL_SB:  legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end else begin
            unique case (load_sel)
                SEL_W:         legal = (addr[1:0] == 2'b00);
                SEL_B, SEL_BU: legal = 1'b1;
                SEL_H, SEL_HU: legal = ~addr[0];
                default:       legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        be_new = 4'b0000;
        wd_new = 32'h0;
        unique case (load_sel)
            SEL_W:         be_new = 4'b1111;
            SEL_H, SEL_HU: be_new = addr[1] ? 4'b1100 : 4'b0011;
            default:       be_new = 4'b0001 << addr[1:0];
        endcase
        if (is_store) begin
            wd_new = (load_sel == SEL_SB) ? {4{wdata[7:0]}} : wdata;
        end
    end

    // Little-endian lane extraction of the returned word.
    always_comb begin
        unique case (lo_q)
            2'd0:    byte_v = bus_rdata[7:0];
            2'd1:    byte_v = bus_rdata[15:8];
            2'd2:    byte_v = bus_rdata[23:16];
            default: byte_v = bus_rdata[31:24];
        endcase
        half_v = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (sel_q)
            SEL_B:   load_v = {{24{byte_v[7]}}, byte_v};
            SEL_BU:  load_v = {24'h0, byte_v};
            SEL_H:   load_v = {{16{half_v[15]}}, half_v};
            SEL_HU:  load_v = {16'h0, half_v};
            default: load_v = bus_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        sel_d   = sel_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && (mem_we || mem_re)) begin
                    if (legal) begin
                        state_d = S_ACCESS;
                        cnt_d   = 16'h0;
                        we_d    = is_store;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        wd_d    = wd_new;
                        sel_d   = load_sel;
                        lo_d    = addr[1:0];
                    end else begin
                        state_d = S_RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                // Ack beats a coincident timeout.
                if (bus_ack) begin
                    state_d = S_RESP;
                    rdata_d = we_q ? 32'h0 : load_v;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'h0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wd_q    <= 32'h0;
            sel_q   <= 4'h0;
            lo_q    <= 2'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            sel_q   <= sel_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign bus_req    = (state_q == S_ACCESS);
    assign resp_valid = (state_q == S_RESP);
    assign rdata      = rdata_q;
    assign err        = err_q;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_be     = be_q;
    assign bus_wdata  = wd_q;

endmodule
